nock_dispatch: RTL and testbench
================================

NOCK_DISPATCH -- requirements
Module: nock_dispatch

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; rst  input  1  asynchronous active-low reset.
REQ-002 SHALL have ports: dispatch_start  input  1  one-cycle request from traversal; dispatch_address  input  `memory_addr_width  address of [subject formula] cell; dispatch_data  input  `memory_data_width  contents of that cell.
REQ-003 SHALL have ports: mem_ready  input  1; read_data1  input  `memory_data_width; mem_execute  output  1; address1  output  `memory_addr_width; mem_func  output  2.
REQ-004 SHALL have ports: mux_select  output  3  drives cell_start of the execute blocks; exec_address  output  `memory_addr_width; exec_data  output  `memory_data_width; exec_finished  input  1  finished from the selected execute block.
REQ-005 SHALL have ports: dispatch_done  output  1  one-cycle completion pulse; dispatch_error  output  8  error code, 0 = none; busy  output  1.
REQ-006 SHALL have parameter WATCHDOG, default 16'hFFFF, meaning the maximum number of cycles to wait for exec_finished.

Function
REQ-007 SHALL implement states IDLE, READ_FORMULA, DECODE, EXECUTE, DONE, ERROR; busy SHALL be 1 in all states except IDLE and ERROR.
REQ-008 IDLE: on dispatch_start=1 SHALL latch dispatch_address/dispatch_data into exec_address/exec_data and clear dispatch_error.
REQ-009 IDLE, same cycle: if dispatch_data[`tel_tag]==`ATOM, SHALL set dispatch_error=8'h01 and go to ERROR.
REQ-010 IDLE, otherwise: SHALL drive address1=dispatch_data[`tel_start:`tel_end], mem_func=`GET_CONTENTS, mem_execute=1, and go to READ_FORMULA.
REQ-011 READ_FORMULA: while mem_ready=0, SHALL drive mem_execute=0 and mem_func=0 from the cycle after the request; mem_execute SHALL therefore be a single-cycle pulse.
REQ-012 READ_FORMULA: on mem_ready=1, SHALL latch read_data1 into an internal formula register and go to DECODE.
REQ-013 DECODE: if formula[`hed_tag]==`CELL (autocons), SHALL set dispatch_error=8'h02 and go to ERROR.
REQ-014 DECODE: the opcode is formula[`hed_start:`hed_end]; if any bit above bit 3 is set, SHALL set dispatch_error=8'h03 and go to ERROR.
REQ-015 DECODE: SHALL map opcode 3 -> `MUX_CELL, 4 -> `MUX_INCR, 5 -> `MUX_EQUAL, then drive mux_select with that value and go to EXECUTE.
REQ-016 DECODE: any other opcode SHALL set dispatch_error=8'h10 | opcode[3:0] and go to ERROR.
REQ-017 EXECUTE: SHALL hold mux_select, exec_address and exec_data stable, and SHALL issue no memory requests (mem_execute=0).
REQ-018 EXECUTE: a 16-bit watchdog SHALL clear on entry and increment each cycle.
REQ-019 EXECUTE: exec_finished=1 SHALL take priority over the watchdog and go to DONE.
REQ-020 EXECUTE: when the watchdog reaches WATCHDOG without exec_finished, SHALL set dispatch_error=8'h04 and go to ERROR.
REQ-021 DONE: SHALL drive mux_select=`MUX_TRAVERSAL and dispatch_done=1 for exactly one cycle, then go to IDLE.
REQ-022 ERROR: SHALL drive mux_select=`MUX_TRAVERSAL and hold dispatch_error.
REQ-023 ERROR: a new dispatch_start SHALL be handled exactly as in IDLE.
REQ-024 dispatch_start while busy=1 SHALL be ignored and SHALL NOT alter the latched address or data.
REQ-025 mux_select SHALL change only on DECODE->EXECUTE and on entry to DONE/ERROR, so that each execute block sees one clean rising edge of its select code.
REQ-026 Latency: dispatch_start to mux_select valid SHALL be 3 cycles plus memory wait cycles.

Reset
REQ-027 On rst=0, asynchronously: state=IDLE, mux_select=`MUX_TRAVERSAL, mem_execute=0, mem_func=0, address1=0, exec_address=0, exec_data=0, dispatch_done=0, dispatch_error=0, busy=0, watchdog=0.
REQ-028 Reset asserted mid-operation in any state SHALL abort the operation with no dispatch_done pulse, and the first operation after release SHALL require a fresh dispatch_start.

Verification
REQ-029 Formula cell with head atom 3, mem_ready after 2 cycles, exec_finished after 5 -> single mem_execute pulse at the tel address, mux_select=`MUX_CELL, one dispatch_done pulse, mux_select back to `MUX_TRAVERSAL.
REQ-030 dispatch_data with tel tag ATOM -> dispatch_error=8'h01, no mem_execute, no dispatch_done.
REQ-031 Head opcodes 4, 5, 7, 27 and a head that is a cell -> `MUX_INCR, `MUX_EQUAL, errors 8'h17, 8'h03 and 8'h02 respectively.
REQ-032 WATCHDOG=16 with exec_finished never asserted -> error 8'h04 after 16 EXECUTE cycles; exec_finished arriving in the same cycle as the timeout -> DONE, no error.
REQ-033 rst pulsed during READ_FORMULA and again during EXECUTE -> all outputs at reset values immediately, second dispatch_start asserted while busy is ignored, and a later start completes normally.

Source files
------------

// File: rtl/nock_dispatch.sv
// nock_dispatch: takes a [subject formula] cell from traversal, fetches the formula,
// decodes its head opcode and hands the cell to the matching execute block.
`ifndef NOCK_DISPATCH_DEFS
`define NOCK_DISPATCH_DEFS
`define MEMORY_ADDR_WIDTH 16
`define MEMORY_DATA_WIDTH 34
`define HED_TAG   33
`define TEL_TAG   32
`define HED_START 31
`define HED_END   16
`define TEL_START 15
`define TEL_END   0
`define ATOM 1'b0
`define CELL 1'b1
`define GET_CONTENTS 2'b01
`define MUX_TRAVERSAL 3'd0
`define MUX_CELL      3'd1
`define MUX_INCR      3'd2
`define MUX_EQUAL     3'd3
`endif

module nock_dispatch #(
  parameter logic [15:0] WATCHDOG = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dispatch_start,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] dispatch_address,
  input  logic [`MEMORY_DATA_WIDTH-1:0] dispatch_data,
  input  logic                          mem_ready,
  input  logic [`MEMORY_DATA_WIDTH-1:0] read_data1,
  output logic                          mem_execute,
  output logic [`MEMORY_ADDR_WIDTH-1:0] address1,
  output logic [1:0]                    mem_func,
  output logic [2:0]                    mux_select,
  output logic [`MEMORY_ADDR_WIDTH-1:0] exec_address,
  output logic [`MEMORY_DATA_WIDTH-1:0] exec_data,
  input  logic                          exec_finished,
  output logic                          dispatch_done,
  output logic [7:0]                    dispatch_error,
  output logic                          busy
);

  typedef enum logic [2:0] {
    IDLE,
    READ_FORMULA,
    DECODE,
    EXECUTE,
    DONE,
    ERROR
  } state_t;

  state_t                          r_state;
  logic [`MEMORY_DATA_WIDTH-1:0]   r_formula;
  logic [15:0]                     r_watchdog;
  logic [15:0]                     w_opcode;
  logic [15:0]                     w_wd_next;
  logic                            w_unused_formula;

  assign w_opcode         = r_formula[`HED_START:`HED_END];
  assign w_wd_next        = r_watchdog + 16'd1;
  assign w_unused_formula = ^r_formula[`TEL_TAG:`TEL_END];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_formula      <= '0;
      r_watchdog     <= '0;
      mux_select     <= `MUX_TRAVERSAL;
      mem_execute    <= 1'b0;
      mem_func       <= 2'b00;
      address1       <= '0;
      exec_address   <= '0;
      exec_data      <= '0;
      dispatch_done  <= 1'b0;
      dispatch_error <= '0;
      busy           <= 1'b0;
    end else begin
      // Memory request and completion strobe are single-cycle pulses.
      mem_execute   <= 1'b0;
      mem_func      <= 2'b00;
      dispatch_done <= 1'b0;
      case (r_state)
        IDLE, ERROR: begin
          if (dispatch_start) begin
            exec_address <= dispatch_address;
            exec_data    <= dispatch_data;
            if (dispatch_data[`TEL_TAG] == `ATOM) begin
              dispatch_error <= 8'h01;
              mux_select     <= `MUX_TRAVERSAL;
              busy           <= 1'b0;
              r_state        <= ERROR;
            end else begin
              dispatch_error <= '0;
              address1       <= dispatch_data[`TEL_START:`TEL_END];
              mem_func       <= `GET_CONTENTS;
              mem_execute    <= 1'b1;
              busy           <= 1'b1;
              r_state        <= READ_FORMULA;
            end
          end
        end
        READ_FORMULA: begin
          if (mem_ready) begin
            r_formula <= read_data1;
            r_state   <= DECODE;
          end
        end
        DECODE: begin
          if (r_formula[`HED_TAG] == `CELL) begin
            dispatch_error <= 8'h02;
            busy           <= 1'b0;
            r_state        <= ERROR;
          end else if (|w_opcode[15:4]) begin
            dispatch_error <= 8'h03;
            busy           <= 1'b0;
            r_state        <= ERROR;
          end else begin
            r_watchdog <= '0;
            case (w_opcode[3:0])
              4'd3: begin
                mux_select <= `MUX_CELL;
                r_state    <= EXECUTE;
              end
              4'd4: begin
                mux_select <= `MUX_INCR;
                r_state    <= EXECUTE;
              end
              4'd5: begin
                mux_select <= `MUX_EQUAL;
                r_state    <= EXECUTE;
              end
              default: begin
                dispatch_error <= {4'h1, w_opcode[3:0]};
                busy           <= 1'b0;
                r_state        <= ERROR;
              end
            endcase
          end
        end
        EXECUTE: begin
          // exec_finished wins even on the cycle the watchdog expires.
          if (exec_finished) begin
            mux_select    <= `MUX_TRAVERSAL;
            dispatch_done <= 1'b1;
            r_state       <= DONE;
          end else if (w_wd_next == WATCHDOG) begin
            mux_select     <= `MUX_TRAVERSAL;
            dispatch_error <= 8'h04;
            busy           <= 1'b0;
            r_watchdog     <= w_wd_next;
            r_state        <= ERROR;
          end else begin
            r_watchdog <= w_wd_next;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          mux_select <= `MUX_TRAVERSAL;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nock_dispatch.sv
// Self-checking bench for nock_dispatch: directed scenarios plus randomized
// transactions checked against an outcome/latency model of the dispatcher.
module tb_nock_dispatch;

    localparam int unsigned WD     = 16;
    localparam int unsigned BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_start;
    logic [15:0] dispatch_address;
    logic [33:0] dispatch_data;
    logic        mem_ready;
    logic [33:0] read_data1;
    logic        mem_execute;
    logic [15:0] address1;
    logic [1:0]  mem_func;
    logic [2:0]  mux_select;
    logic [15:0] exec_address;
    logic [33:0] exec_data;
    logic        exec_finished;
    logic        dispatch_done;
    logic [7:0]  dispatch_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    nock_dispatch #(.WATCHDOG(16'(WD))) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_start   (dispatch_start),
        .dispatch_address (dispatch_address),
        .dispatch_data    (dispatch_data),
        .mem_ready        (mem_ready),
        .read_data1       (read_data1),
        .mem_execute      (mem_execute),
        .address1         (address1),
        .mem_func         (mem_func),
        .mux_select       (mux_select),
        .exec_address     (exec_address),
        .exec_data        (exec_data),
        .exec_finished    (exec_finished),
        .dispatch_done    (dispatch_done),
        .dispatch_error   (dispatch_error),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Word layout: [33] head tag, [32] tail tag, [31:16] head, [15:0] tail; tag 1 = cell.
    function automatic logic [33:0] mk(input logic htag, input logic ttag,
                                       input logic [15:0] hed, input logic [15:0] tel);
        return {htag, ttag, hed, tel};
    endfunction

    function automatic logic [33:0] rnd34();
        return 34'({$urandom(), $urandom()});
    endfunction

    // Decode outcome: error code (0 = none) and select code of the chosen block.
    function automatic logic [7:0] model_code(input logic [33:0] data, input logic [33:0] formula,
                                              output logic [2:0] mux);
        int unsigned op;
        op  = int'(formula[31:16]);
        mux = 3'd0;
        if (data[32] == 1'b0) return 8'h01;
        if (formula[33] == 1'b1) return 8'h02;
        if (op >= 16) return 8'h03;
        if (op == 3) begin mux = 3'd1; return 8'h00; end
        if (op == 4) begin mux = 3'd2; return 8'h00; end
        if (op == 5) begin mux = 3'd3; return 8'h00; end
        return 8'(8'h10 + op);
    endfunction

    task automatic run_dispatch(input string name, input logic [15:0] addr, input logic [33:0] data,
                                input logic [33:0] formula, input int unsigned mem_wait,
                                input int unsigned exec_delay, input int unsigned noise_cycle);
        logic [7:0]  exp_err;
        logic [2:0]  exp_mux;
        logic        exp_mem;
        int          exp_end;
        int          c, req_c, mux_c, mem_pulses, stray_func, done_pulses, mux_changes;
        logic        ready_given;
        logic [15:0] req_addr;
        logic [1:0]  req_func;
        logic [2:0]  prev_mux, mux_seen;

        exp_err = model_code(data, formula, exp_mux);
        exp_mem = data[32];
        if (exp_err == 8'h01)      exp_end = 1;
        else if (exp_mux == 3'd0)  exp_end = 3 + int'(mem_wait);
        else if (exec_delay > WD) begin
            exp_err = 8'h04;
            exp_end = 3 + int'(mem_wait) + int'(WD);
        end else                   exp_end = 3 + int'(mem_wait) + int'(exec_delay) + 1;

        req_c = -1; mux_c = -1; mem_pulses = 0; stray_func = 0; done_pulses = 0;
        mux_changes = 0; ready_given = 1'b0; req_addr = '0; req_func = '0; mux_seen = '0;

        @(negedge clk);
        prev_mux         = mux_select;
        dispatch_address = addr;
        dispatch_data    = data;
        dispatch_start   = 1'b1;
        @(negedge clk);
        dispatch_start   = 1'b0;
        dispatch_address = 16'($urandom());
        dispatch_data    = rnd34();
        c = 1;
        while (c < int'(BUDGET)) begin
            if (mem_execute) begin
                mem_pulses++;
                req_addr = address1;
                req_func = mem_func;
                req_c    = c;
            end else if (mem_func != 2'b00) stray_func++;
            if (mux_select !== prev_mux) begin
                mux_changes++;
                if (mux_c < 0 && mux_select != 3'd0) begin
                    mux_c    = c;
                    mux_seen = mux_select;
                end
                prev_mux = mux_select;
            end
            if (dispatch_done) done_pulses++;
            if (!busy) break;
            mem_ready = 1'b0;
            if (req_c >= 0 && !ready_given && c >= req_c + int'(mem_wait)) begin
                mem_ready   = 1'b1;
                read_data1  = formula;
                ready_given = 1'b1;
            end
            exec_finished  = (mux_c >= 0 && mux_select != 3'd0 && c == mux_c + int'(exec_delay) - 1);
            dispatch_start = 1'b0;
            if (c == int'(noise_cycle)) begin
                dispatch_start   = 1'b1;
                dispatch_address = 16'($urandom());
                dispatch_data    = rnd34();
            end
            @(negedge clk);
            c++;
        end
        dispatch_start = 1'b0;
        mem_ready      = 1'b0;
        exec_finished  = 1'b0;

        checks++;
        if (c >= int'(BUDGET)) begin
            errors++;
            $display("FAIL %s timeout: busy never dropped within %0d cycles", name, BUDGET);
        end
        checks++;
        if (c !== exp_end) begin
            errors++;
            $display("FAIL %s end_cycle: got %0d expected %0d", name, c, exp_end);
        end
        checks++;
        if (mem_pulses !== (exp_mem ? 1 : 0) || stray_func !== 0) begin
            errors++;
            $display("FAIL %s mem_execute_pulses: got %0d (stray func %0d) expected %0d",
                     name, mem_pulses, stray_func, exp_mem ? 1 : 0);
        end
        if (exp_mem) begin
            checks++;
            if (req_addr !== data[15:0] || req_func !== 2'b01) begin
                errors++;
                $display("FAIL %s mem_request: got addr %0h func %0d expected addr %0h func 1",
                         name, req_addr, req_func, data[15:0]);
            end
        end
        checks++;
        if (done_pulses !== ((exp_err == 8'h00) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected %0d", name, done_pulses,
                     (exp_err == 8'h00) ? 1 : 0);
        end
        checks++;
        if (dispatch_error !== exp_err) begin
            errors++;
            $display("FAIL %s dispatch_error: got %02h expected %02h", name, dispatch_error, exp_err);
        end
        checks++;
        if (exp_mux != 3'd0) begin
            if (mux_seen !== exp_mux || mux_c !== 3 + int'(mem_wait) || mux_changes !== 2) begin
                errors++;
                $display("FAIL %s mux_select: got %0d at cycle %0d (%0d changes) expected %0d at cycle %0d (2 changes)",
                         name, mux_seen, mux_c, mux_changes, exp_mux, 3 + int'(mem_wait));
            end
        end else if (mux_changes !== 0) begin
            errors++;
            $display("FAIL %s mux_select: got %0d changes expected 0", name, mux_changes);
        end
        checks++;
        if (exec_address !== addr || exec_data !== data || mux_select !== 3'd0) begin
            errors++;
            $display("FAIL %s latched: got addr %0h data %0h mux %0d expected addr %0h data %0h mux 0",
                     name, exec_address, exec_data, mux_select, addr, data);
        end
    endtask

    task automatic test_reset();
        logic [76:0] outs;
        int          bad;
        rst = 1'b1;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph > 0) begin
                @(negedge clk);
                dispatch_address = 16'h1234;
                dispatch_data    = mk(1'b0, 1'b1, 16'd3, 16'h0042);
                read_data1       = mk(1'b0, 1'b0, 16'd3, 16'h0000);
                dispatch_start   = 1'b1;
                @(negedge clk);
                dispatch_start   = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    if ((ph == 1 && mem_execute) || (ph == 2 && mux_select != 3'd0)) break;
                    mem_ready = (ph == 2);
                    @(negedge clk);
                end
                mem_ready = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_phase%0d_setup: got busy %0b expected 1", ph, busy);
                end
            end
            #2 rst = 1'b0;
            #1;
            outs = {mux_select, mem_execute, mem_func, address1, exec_address, exec_data,
                    dispatch_done, dispatch_error, busy};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_phase%0d_outputs: got %h expected 0", ph, outs);
            end
            @(negedge clk);
            rst = 1'b1;
            bad = 0;
            for (int i = 0; i < 6; i++) begin
                mem_ready     = 1'b1;
                exec_finished = 1'b1;
                @(negedge clk);
                if (busy || dispatch_done || mem_execute || mux_select != 3'd0) bad++;
            end
            mem_ready     = 1'b0;
            exec_finished = 1'b0;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL reset_phase%0d_idle_after_release: got %0d active cycles expected 0", ph, bad);
            end
        end
    endtask

    task automatic test_formula_cell();
        run_dispatch("formula_cell_op3", 16'hA5A5, mk(1'b0, 1'b1, 16'h0777, 16'h0123),
                     mk(1'b0, 1'b1, 16'd3, 16'h4444), 2, 5, 0);
    endtask

    task automatic test_atom_tel();
        run_dispatch("atom_tel", 16'h0010, mk(1'b1, 1'b0, 16'h0003, 16'h0099),
                     mk(1'b0, 1'b0, 16'd3, 16'h0000), 0, 3, 0);
    endtask

    task automatic test_opcodes();
        logic [15:0] ops [4] = '{16'd4, 16'd5, 16'd7, 16'd27};
        foreach (ops[i])
            run_dispatch($sformatf("opcode_%0d", ops[i]), 16'($urandom()),
                         mk(1'b0, 1'b1, 16'($urandom()), 16'($urandom())),
                         mk(1'b0, 1'(i), ops[i], 16'($urandom())),
                         $urandom_range(0, 3), $urandom_range(1, 6), 0);
        run_dispatch("head_cell", 16'h0BEE, mk(1'b0, 1'b1, 16'h0001, 16'h0200),
                     mk(1'b1, 1'b0, 16'd3, 16'h0000), 1, 2, 0);
    endtask

    task automatic test_watchdog();
        run_dispatch("watchdog_timeout", 16'h0F0F, mk(1'b0, 1'b1, 16'h0000, 16'h0300),
                     mk(1'b0, 1'b0, 16'd4, 16'h0000), 1, 1000, 0);
        run_dispatch("watchdog_same_cycle_finish", 16'h0F10, mk(1'b0, 1'b1, 16'h0000, 16'h0301),
                     mk(1'b0, 1'b0, 16'd5, 16'h0000), 0, WD, 0);
        run_dispatch("watchdog_one_early", 16'h0F11, mk(1'b0, 1'b1, 16'h0000, 16'h0302),
                     mk(1'b0, 1'b0, 16'd3, 16'h0000), 0, WD - 1, 0);
    endtask

    task automatic test_busy_ignore();
        run_dispatch("start_while_busy", 16'h2222, mk(1'b0, 1'b1, 16'h0000, 16'h0444),
                     mk(1'b0, 1'b0, 16'd3, 16'h0000), 2, 4, 2);
        run_dispatch("start_while_executing", 16'h3333, mk(1'b0, 1'b1, 16'h0000, 16'h0555),
                     mk(1'b0, 1'b0, 16'd4, 16'h0000), 0, 6, 5);
    endtask

    task automatic test_back_to_back();
        logic [33:0] d, f;
        logic [15:0] op;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 6) op = 16'($urandom_range(3, 5));
            else                          op = 16'($urandom_range(0, 40));
            d = mk(1'($urandom()), ($urandom_range(0, 9) != 0), 16'($urandom()), 16'($urandom()));
            f = mk(($urandom_range(0, 9) == 0), 1'($urandom()), op, 16'($urandom()));
            run_dispatch($sformatf("random_%0d", n), 16'($urandom()), d, f,
                         $urandom_range(0, 4), $urandom_range(1, 8), $urandom_range(0, 12));
        end
    endtask

    initial begin
        rst = 1'b1; dispatch_start = 1'b0; dispatch_address = '0; dispatch_data = '0;
        mem_ready = 1'b0; read_data1 = '0; exec_finished = 1'b0;
        test_reset();
        test_formula_cell();
        test_atom_tel();
        test_opcodes();
        test_watchdog();
        test_busy_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
